gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised global-history branch predictor for the pipelined core, sitting between ID (lookup) and EX (resolve). It indexes a table of saturating counters with PC bits XORed with a global branch history register and returns a registered taken/not-taken prediction. On reset, a sequential initialisation pass clears the table. EX resolutions train the table and shift the history.

## Interface
Parameters:
- HIST_W, 4, global history length in bits; must satisfy 1 ≤ HIST_W ≤ IDX_W
- IDX_W, 6, table index width; the table has 2^IDX_W entries
- CNT_W, 2, saturating counter width; must be ≥ 2
- PC_W, 32, program counter width; must be ≥ IDX_W+2

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Ready  out  1  high once table initialisation is complete
- LookupValid  in  1  ID stage holds a branch
- LookupPC  in  PC_W  PC of the ID branch
- PredValid  out  1  Prediction/PredIndex valid this cycle
- Prediction  out  1  1 = predict taken
- PredIndex  out  IDX_W  table index used; piped to EX with the branch
- UpdateValid  in  1  EX stage resolves a branch
- UpdateIndex  in  IDX_W  PredIndex carried with the resolving branch
- UpdateTaken  in  1  resolved direction

## Operation
- States: INIT, READY.
  - Reset forces INIT and clears the init counter to 0.
  - INIT writes one entry per cycle, entry 0 up to entry 2^IDX_W−1, with weakly-not-taken = 2^(CNT_W−1)−1.
  - After the last write the FSM moves to READY and stays there until Reset.
- Output reset values: Ready=0, PredValid=0, Prediction=0, PredIndex=0. History register = 0.
- During INIT:
  - LookupValid yields PredValid=1, Prediction=0, PredIndex=computed index.
  - UpdateValid is ignored: no counter change, no history shift.
- Index: idx = LookupPC[IDX_W+1:2] XOR zero-extend(History) to IDX_W bits.
- Prediction = MSB of counter[idx].
- Update, in READY with UpdateValid:
  - UpdateTaken=1: counter[UpdateIndex] increments, saturating at 2^CNT_W−1.
  - UpdateTaken=0: counter[UpdateIndex] decrements, saturating at 0.
  - History ← {History[HIST_W−2:0], UpdateTaken}. For HIST_W=1, History ← UpdateTaken.
- History is non-speculative: it changes only on resolution, never on lookup.
- Simultaneous lookup and update:
  - Lookup uses the pre-update History and pre-update counter value (read-before-write), including when the indexes are equal.
- Reset asserted mid-operation: INIT restarts next cycle. Any in-flight PredIndex in the pipe is meaningless, and its updates are dropped while in INIT.

## Timing
- Lookup latency is 1 cycle. LookupValid in cycle t gives PredValid/Prediction/PredIndex registered at edge t+1. PredValid=0 when LookupValid=0, and Prediction is forced to 0 then.
- An update is visible to lookups issued in the cycle after UpdateValid.
- INIT lasts exactly 2^IDX_W cycles after Reset deasserts. Ready rises at the edge ending the last write (64 cycles for the defaults).
- No backpressure: one lookup and one update may be accepted every cycle.

## Configuration
- GSHARE_XOR_EN defined: index = PC bits XOR History (gshare).
- GSHARE_XOR_EN undefined: index = LookupPC[IDX_W+1:2] only (bimodal, per-PC). History is still maintained but does not affect indexing.
- All other behaviour is identical in both builds.

## Structure
- The shared package `bp_pkg` holds:
  - state enum (INIT, READY)
  - function for the weakly-not-taken constant
  - saturating inc/dec function parameterised on CNT_W
- One natural sub-module, `sat_counter_table`:
  - 2^IDX_W × CNT_W array
  - one read port, one read-modify-write port
  - init write port
- The top level holds the FSM, the history register and the index logic.

## Test plan
- Reset for 1 cycle, then idle: Ready=0 for 64 cycles, then Ready=1. A lookup during INIT returns Prediction=0. An update during INIT leaves History=0.
- Defaults with GSHARE_XOR_EN, History=0, lookup PC=0x40:
  - PredIndex=0x10, Prediction=0.
  - One update (idx 0x10, taken) → History=0001 and counter=2.
  - Lookup PC=0x40 now indexes 0x11 and predicts 0.
- Five taken updates to idx 0x10, then one not-taken → counter 3→2. A lookup hitting 0x10 predicts 1.
- Update sequence T,T,NT,T → History=4'b1101. Lookup PC=0x40 → PredIndex=0x1D. Without GSHARE_XOR_EN → PredIndex=0x10.
- Same-cycle lookup and update on idx 0x10 with counter=1, taken → lookup returns 0. The next-cycle lookup returns 1.
- Reset asserted mid-stream in READY → Ready=0 next cycle, all counters back to 1, History=0, and 64 cycles of INIT repeat.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor blocks.
package bp_pkg;

  localparam int CNT_MAX_W = 16;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bp_state_e;

  function automatic logic [CNT_MAX_W-1:0] weak_not_taken(input int cnt_w);
    return CNT_MAX_W'((32'd1 << (cnt_w - 1)) - 32'd1);
  endfunction

  // Saturating step toward taken (increment) or not-taken (decrement).
  function automatic logic [CNT_MAX_W-1:0] sat_step(input logic [CNT_MAX_W-1:0] cnt,
                                                    input logic taken,
                                                    input int cnt_w);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
    if (taken) begin
      return (cnt == max_v) ? cnt : cnt + 16'd1;
    end else begin
      return (cnt == 16'd0) ? cnt : cnt - 16'd1;
    end
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters: asynchronous read port, read-modify-write
// training port and an init write port that takes priority over training.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
) (
  input  logic             Clk,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0] o_rd_cnt,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic             i_init_en,
  input  logic [IDX_W-1:0] i_init_idx,
  input  logic [CNT_W-1:0] i_init_val
);

  logic [CNT_W-1:0] r_table [2**IDX_W];
  logic [CNT_W-1:0] w_upd_cur;
  logic [CNT_W-1:0] w_upd_next;

  assign o_rd_cnt   = r_table[i_rd_idx];
  assign w_upd_cur  = r_table[i_upd_idx];
  assign w_upd_next = CNT_W'(sat_step(CNT_MAX_W'(w_upd_cur), i_upd_taken, CNT_W));

  // counter storage; the read port sees the pre-edge value (read-before-write)
  always_ff @(posedge Clk) begin
    if (i_init_en) begin
      r_table[i_init_idx] <= i_init_val;
    end else if (i_upd_en) begin
      r_table[i_upd_idx] <= w_upd_next;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch predictor: FSM, history register and index logic.
// Define GSHARE_XOR_EN to XOR the history into the index (gshare); otherwise bimodal.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int HIST_W = 4,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int PC_W   = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             Ready,
  input  logic             LookupValid,
  input  logic [PC_W-1:0]  LookupPC,
  output logic             PredValid,
  output logic             Prediction,
  output logic [IDX_W-1:0] PredIndex,
  input  logic             UpdateValid,
  input  logic [IDX_W-1:0] UpdateIndex,
  input  logic             UpdateTaken
);

  bp_state_e        r_state;
  bp_state_e        w_state_next;
  logic [IDX_W-1:0] r_init_cnt;
  logic [HIST_W-1:0] r_hist;
  logic             r_ready;
  logic             r_pred_valid;
  logic             r_prediction;
  logic [IDX_W-1:0] r_pred_index;

  logic             w_init_en;
  logic             w_upd_en;
  logic             w_last_init;
  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_rd_cnt;
  logic [CNT_W-1:0] w_init_val;
  logic [HIST_W:0]  w_hist_shift;
  logic             w_unused_pc;

  assign w_last_init  = &r_init_cnt;
  assign w_init_val   = CNT_W'(weak_not_taken(CNT_W));
  assign w_hist_shift = {r_hist, UpdateTaken};
  assign w_pc_idx     = LookupPC[IDX_W+1:2];
  assign w_unused_pc  = ^{LookupPC[PC_W-1:IDX_W+2], LookupPC[1:0]};

`ifdef GSHARE_XOR_EN
  logic [IDX_W-1:0] w_hist_ext;
  assign w_hist_ext = IDX_W'(r_hist);
  assign w_idx      = w_pc_idx ^ w_hist_ext;
`else
  assign w_idx      = w_pc_idx;
`endif

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state: leave INIT after the last entry is written
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (w_last_init) begin
          w_state_next = ST_READY;
        end else begin
          w_state_next = ST_INIT;
        end
      end
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_INIT;
    endcase
  end

  // state-dependent enables; training is ignored until the table is clean
  always_comb begin
    w_init_en = 1'b0;
    w_upd_en  = 1'b0;
    case (r_state)
      ST_INIT:  w_init_en = ~Reset;
      ST_READY: w_upd_en  = UpdateValid & ~Reset;
      default: begin
        w_init_en = 1'b0;
        w_upd_en  = 1'b0;
      end
    endcase
  end

  // init pointer and non-speculative history
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_init_cnt <= '0;
      r_hist     <= '0;
    end else begin
      if (w_init_en) begin
        r_init_cnt <= r_init_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (w_upd_en) begin
        r_hist <= w_hist_shift[HIST_W-1:0];
      end
    end
  end

  // registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ready      <= 1'b0;
      r_pred_valid <= 1'b0;
      r_prediction <= 1'b0;
      r_pred_index <= '0;
    end else begin
      r_ready      <= (w_state_next == ST_READY);
      r_pred_valid <= LookupValid;
      r_prediction <= LookupValid & (r_state == ST_READY) & w_rd_cnt[CNT_W-1];
      r_pred_index <= w_idx;
    end
  end

  assign Ready      = r_ready;
  assign PredValid  = r_pred_valid;
  assign Prediction = r_prediction;
  assign PredIndex  = r_pred_index;

  sat_counter_table #(
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) u_table (
    .Clk        (Clk),
    .i_rd_idx   (w_idx),
    .o_rd_cnt   (w_rd_cnt),
    .i_upd_en   (w_upd_en),
    .i_upd_idx  (UpdateIndex),
    .i_upd_taken(UpdateTaken),
    .i_init_en  (w_init_en),
    .i_init_idx (r_init_cnt),
    .i_init_val (w_init_val)
  );

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: table-level model plus directed literals.
module tb_gshare_predictor;

  localparam int HIST_W = 4;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 2;
  localparam int PC_W   = 32;
  localparam int N      = 64;
`ifdef GSHARE_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic             Clk;
  logic             Reset;
  logic             Ready;
  logic             LookupValid;
  logic [PC_W-1:0]  LookupPC;
  logic             PredValid;
  logic             Prediction;
  logic [IDX_W-1:0] PredIndex;
  logic             UpdateValid;
  logic [IDX_W-1:0] UpdateIndex;
  logic             UpdateTaken;

  gshare_predictor #(
    .HIST_W(HIST_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .PC_W(PC_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Ready(Ready),
    .LookupValid(LookupValid), .LookupPC(LookupPC),
    .PredValid(PredValid), .Prediction(Prediction), .PredIndex(PredIndex),
    .UpdateValid(UpdateValid), .UpdateIndex(UpdateIndex), .UpdateTaken(UpdateTaken)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counter values per entry, history as an integer, cycles of init left.
  int cnt_m [N];
  int hist_m;
  int init_left;
  bit rst_seen = 1'b0;
  bit e_ready, e_pv, e_pred;
  int e_idx;

  function automatic int model_idx(input logic [31:0] pc);
    int p;
    p = int'(pc >> 2) % N;
    return XOR_EN ? (p ^ hist_m) : p;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      rst_seen  = 1'b1;
      init_left = N;
      hist_m    = 0;
      for (int i = 0; i < N; i++) cnt_m[i] = (1 << (CNT_W - 1)) - 1;
      e_ready = 1'b0; e_pv = 1'b0; e_pred = 1'b0; e_idx = 0;
    end else if (rst_seen) begin
      e_pv   = LookupValid;
      e_pred = 1'b0;
      if (LookupValid) begin
        e_idx  = model_idx(LookupPC);
        e_pred = (init_left == 0) && (cnt_m[e_idx] >= (1 << (CNT_W - 1)));
      end
      if (UpdateValid && init_left == 0) begin
        if (UpdateTaken) cnt_m[UpdateIndex] = (cnt_m[UpdateIndex] == (1 << CNT_W) - 1) ? cnt_m[UpdateIndex] : cnt_m[UpdateIndex] + 1;
        else             cnt_m[UpdateIndex] = (cnt_m[UpdateIndex] == 0) ? 0 : cnt_m[UpdateIndex] - 1;
        hist_m = (hist_m * 2 + int'(UpdateTaken)) % (1 << HIST_W);
      end
      if (init_left > 0) init_left--;
      e_ready = (init_left == 0);
    end
    #1;
    if (rst_seen) begin
      check("ready", 32'(Ready), 32'(e_ready));
      check("pred_valid", 32'(PredValid), 32'(e_pv));
      check("prediction", 32'(Prediction), 32'(e_pred));
      if (e_pv || Reset) check("pred_index", 32'(PredIndex), 32'(e_pv ? e_idx : 0));
    end
  end

  task automatic lookup(input logic [31:0] pc);
    LookupValid = 1'b1; LookupPC = pc;
    @(negedge Clk);
    LookupValid = 1'b0;
  endtask

  task automatic update(input int idx, input logic t);
    UpdateValid = 1'b1; UpdateIndex = IDX_W'(idx); UpdateTaken = t;
    @(negedge Clk);
    UpdateValid = 1'b0;
  endtask

  task automatic both(input logic [31:0] pc, input int idx, input logic t);
    LookupValid = 1'b1; LookupPC = pc;
    UpdateValid = 1'b1; UpdateIndex = IDX_W'(idx); UpdateTaken = t;
    @(negedge Clk);
    LookupValid = 1'b0; UpdateValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; LookupValid = 1'b0; LookupPC = '0;
    UpdateValid = 1'b0; UpdateIndex = '0; UpdateTaken = 1'b0;
    @(negedge Clk);
    check("reset_ready", 32'(Ready), 32'd0);
    check("reset_pred_index", 32'(PredIndex), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // INIT: lookup predicts not-taken, update is dropped, Ready after 64 cycles
    lookup(32'h40);
    check("init_pred_valid", 32'(PredValid), 32'd1);
    check("init_prediction", 32'(Prediction), 32'd0);
    check("init_pred_index", 32'(PredIndex), 32'h10);
    update(6'h10, 1'b1);
    repeat (61) @(negedge Clk);
    check("init_ready_63", 32'(Ready), 32'd0);
    @(negedge Clk);
    check("init_ready_64", 32'(Ready), 32'd1);

    lookup(32'h40);
    check("first_idx", 32'(PredIndex), 32'h10);
    check("first_pred", 32'(Prediction), 32'd0);

    update(6'h10, 1'b1);
    lookup(32'h40);
    check("hist1_idx", 32'(PredIndex), XOR_EN ? 32'h11 : 32'h10);
    check("hist1_pred", 32'(Prediction), XOR_EN ? 32'd0 : 32'd1);

    repeat (5) update(6'h10, 1'b1);
    update(6'h10, 1'b0);
    lookup(XOR_EN ? 32'h78 : 32'h40);
    check("sat_idx", 32'(PredIndex), 32'h10);
    check("sat_pred", 32'(Prediction), 32'd1);

    update(6'h20, 1'b1); update(6'h20, 1'b1); update(6'h20, 1'b0); update(6'h20, 1'b1);
    lookup(32'h40);
    check("hist1101_idx", 32'(PredIndex), XOR_EN ? 32'h1D : 32'h10);
    check("hist1101_pred", 32'(Prediction), XOR_EN ? 32'd0 : 32'd1);

    update(6'h10, 1'b0);
    both(XOR_EN ? 32'h68 : 32'h40, 6'h10, 1'b1);
    check("rbw_idx", 32'(PredIndex), 32'h10);
    check("rbw_pred", 32'(Prediction), 32'd0);
    lookup(XOR_EN ? 32'h54 : 32'h40);
    check("after_rbw_idx", 32'(PredIndex), 32'h10);
    check("after_rbw_pred", 32'(Prediction), 32'd1);

    for (int i = 0; i < 300; i++) begin
      LookupValid = 1'($urandom); LookupPC = $urandom;
      UpdateValid = 1'($urandom); UpdateIndex = IDX_W'($urandom); UpdateTaken = 1'($urandom);
      @(negedge Clk);
    end
    LookupValid = 1'b0; UpdateValid = 1'b0;

    // Mid-stream reset: trained entry must return to weakly-not-taken
    repeat (3) update(6'h10, 1'b1);
    Reset = 1'b1; UpdateValid = 1'b1; UpdateIndex = 6'h10; UpdateTaken = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; UpdateValid = 1'b0;
    check("rst2_ready", 32'(Ready), 32'd0);
    update(6'h10, 1'b1);
    repeat (62) @(negedge Clk);
    check("rst2_ready_63", 32'(Ready), 32'd0);
    @(negedge Clk);
    check("rst2_ready_64", 32'(Ready), 32'd1);
    lookup(32'h40);
    check("rst2_idx", 32'(PredIndex), 32'h10);
    check("rst2_pred", 32'(Prediction), 32'd0);
    repeat (2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
